// File: rtl/rst_sequencer_pkg.sv
// Shared definitions for the reset sequencer: reset-cause codes, the
// sequencer state encoding and a counter sizing helper.
package rst_sequencer_pkg;

    // Cause of the most recent reset, shown on the status display.
    localparam logic [1:0] CAUSE_POR  = 2'b01;
    localparam logic [1:0] CAUSE_BTN  = 2'b10;
    localparam logic [1:0] CAUSE_SOFT = 2'b11;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_STRETCH = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } rst_state_t;

    // Bits needed to hold values 0..max_count (never less than one bit).
    function automatic int cnt_width(input int max_count);
        return (max_count < 2) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/sync_debounce.sv
// Synchronizer plus debouncer for an active-low, bouncy, asynchronous input.
// The output only follows the input once it has been stable for
// DEBOUNCE_CYCLES consecutive synchronized samples. Both the synchronizer
// and the debounced level come out of reset high (button not pressed).
module sync_debounce
    import rst_sequencer_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1200
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din_async,
    output logic dout
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level_q;
    logic [CW-1:0]          cnt_q;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    // Metastability chain bringing the raw pin into the clk domain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din_async};
        end
    end

    // Count consecutive samples that disagree with the accepted level; any
    // agreeing sample clears the count, so a bounce restarts the wait.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_q <= 1'b1;
            cnt_q   <= '0;
        end else if (synced != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_q <= ~level_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end else begin
            cnt_q <= '0;
        end
    end

    // The accepted level drives the output directly.
    always_comb begin
        dout = level_q;
    end

endmodule

// File: rtl/rst_sequencer.sv
// Reset sequencer: asserts all downstream resets asynchronously with the
// board reset, then releases them synchronously after a stretch, one output
// at a time, STAGE_GAP cycles apart. A debounced push button or a soft-reset
// pulse restarts the sequence from the stretch phase; the last cause is held
// for status readout.
//
// Handshake note: soft_rst is a plain single-cycle request sampled on clk;
// there is no acknowledge. The button request is level-based: while the
// debounced button is held low the sequence is parked at stretch count 0.
module rst_sequencer
    import rst_sequencer_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int STRETCH_CYCLES  = 16,
    parameter int NUM_OUTS        = 3,
    parameter int STAGE_GAP       = 4,
    parameter int DEBOUNCE_CYCLES = 1200
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                btn_rst_n,
    input  logic                soft_rst,
    output logic [NUM_OUTS-1:0] rst_out_n,
    output logic                ready,
    output logic [1:0]          rst_cause
);

    localparam int                  SW           = cnt_width(STRETCH_CYCLES);
    localparam int                  GW           = cnt_width(STAGE_GAP - 1);
    localparam logic [SW-1:0]       STRETCH_LAST = SW'(STRETCH_CYCLES - 1);
    localparam logic [GW-1:0]       GAP_LAST     = GW'(STAGE_GAP - 1);
    localparam logic [NUM_OUTS-1:0] FIRST_BIT    = NUM_OUTS'(1);

    logic [SYNC_STAGES-1:0] rst_sync_q;
    logic                   rst_synced;
    logic                   btn_db;
    logic                   restart;

    rst_state_t             state_q, state_d;
    logic [SW-1:0]          stretch_q, stretch_d;
    logic [GW-1:0]          gap_q, gap_d;
    logic [NUM_OUTS-1:0]    rel_q, rel_d;
    logic [1:0]             cause_q, cause_d;

    // Board reset release synchronizer: asserts asynchronously, releases
    // SYNC_STAGES edges after reset_n rises.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_synced = rst_sync_q[SYNC_STAGES-1];

    sync_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk       (clk),
        .reset_n   (reset_n),
        .din_async (btn_rst_n),
        .dout      (btn_db)
    );

    // Restart requests only count once the sequencer has left HOLD.
    assign restart = (state_q != ST_HOLD) && (!btn_db || soft_rst);

    // State register together with the stretch/stage counters and cause.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_HOLD;
            stretch_q <= '0;
            gap_q     <= '0;
            rel_q     <= '0;
            cause_q   <= CAUSE_POR;
        end else begin
            state_q   <= state_d;
            stretch_q <= stretch_d;
            gap_q     <= gap_d;
            rel_q     <= rel_d;
            cause_q   <= cause_d;
        end
    end

    // Next-state and counter update; a restart overrides every state.
    always_comb begin
        state_d   = state_q;
        stretch_d = stretch_q;
        gap_d     = gap_q;
        rel_d     = rel_q;
        cause_d   = cause_q;

        case (state_q)
            ST_HOLD: begin
                // The edge that leaves HOLD is the first stretch edge.
                if (rst_synced) begin
                    if (STRETCH_CYCLES == 1) begin
                        state_d = ST_RELEASE;
                        rel_d   = FIRST_BIT;
                        gap_d   = '0;
                    end else begin
                        state_d   = ST_STRETCH;
                        stretch_d = SW'(1);
                    end
                end
            end
            ST_STRETCH: begin
                if (stretch_q >= STRETCH_LAST) begin
                    state_d   = ST_RELEASE;
                    stretch_d = '0;
                    rel_d     = FIRST_BIT;
                    gap_d     = '0;
                end else begin
                    stretch_d = stretch_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                if (&rel_q) begin
                    state_d = ST_RUN;
                end else if (gap_q >= GAP_LAST) begin
                    rel_d = (rel_q << 1) | FIRST_BIT;
                    gap_d = '0;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_HOLD;
            end
        endcase

        if (restart) begin
            state_d   = ST_STRETCH;
            stretch_d = '0;
            gap_d     = '0;
            rel_d     = '0;
            cause_d   = !btn_db ? CAUSE_BTN : CAUSE_SOFT;
        end
    end

    // Outputs: released bits, ready once in RUN, and the latched cause.
    always_comb begin
        rst_out_n = rel_q;
        ready     = (state_q == ST_RUN);
        rst_cause = cause_q;
    end

endmodule

// File: tb/tb_rst_sequencer.sv
// Self-checking bench for rst_sequencer (DEBOUNCE_CYCLES shortened to 8).
// Expected {ready, rst_cause, rst_out_n} values are queued against the clk
// edge number at which they must hold, and compared on the following
// falling edge.
module tb_rst_sequencer;

    localparam int NUM_OUTS = 3;

    logic                clk;
    logic                reset_n;
    logic                btn_rst_n;
    logic                soft_rst;
    logic [NUM_OUTS-1:0] rst_out_n;
    logic                ready;
    logic [1:0]          rst_cause;

    int n_checks = 0;
    int n_errors = 0;
    int edge_cnt = 0;

    logic [5:0] exp_q[$];
    int         exp_edge_q[$];
    string      exp_tag_q[$];

    rst_sequencer #(
        .SYNC_STAGES     (2),
        .STRETCH_CYCLES  (16),
        .NUM_OUTS        (NUM_OUTS),
        .STAGE_GAP       (4),
        .DEBOUNCE_CYCLES (8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .btn_rst_n (btn_rst_n),
        .soft_rst  (soft_rst),
        .rst_out_n (rst_out_n),
        .ready     (ready),
        .rst_cause (rst_cause)
    );

    // ---------------- clock / edge counter / watchdog ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    function automatic logic [5:0] observed();
        return {ready, rst_cause, rst_out_n};
    endfunction

    task automatic check_eq(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got {rdy,cause,out}=%b_%b_%b expected %b_%b_%b (edge %0d)",
                     tag, obs[5], obs[4:3], obs[2:0], exp[5], exp[4:3], exp[2:0], edge_cnt);
        end
    endtask

    task automatic push_exp(input int e, input logic [5:0] v, input string tag);
        exp_edge_q.push_back(e);
        exp_q.push_back(v);
        exp_tag_q.push_back(tag);
    endtask

    // Scoreboard: compare everything due at or before the last edge.
    always @(negedge clk) begin
        while (exp_edge_q.size() > 0 && exp_edge_q[0] <= edge_cnt) begin
            check_eq(exp_tag_q.pop_front(), observed(), exp_q.pop_front());
            void'(exp_edge_q.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_negedges(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Release reset_n from low and expect the full default release timing.
    task automatic por_sequence();
        int b;
        b = edge_cnt;
        reset_n = 1'b1;
        push_exp(b + 17, 6'b0_01_000, "por_e17");
        push_exp(b + 18, 6'b0_01_001, "por_e18");
        push_exp(b + 21, 6'b0_01_001, "por_e21");
        push_exp(b + 22, 6'b0_01_011, "por_e22");
        push_exp(b + 25, 6'b0_01_011, "por_e25");
        push_exp(b + 26, 6'b0_01_111, "por_e26");
        push_exp(b + 27, 6'b1_01_111, "por_ready");
        wait_negedges(30);
    endtask

    // One soft_rst pulse from RUN, then the full stretch/release.
    task automatic soft_pulse_run();
        int n;
        n = edge_cnt + 1;
        soft_rst = 1'b1;
        push_exp(n,      6'b0_11_000, "soft_assert");
        push_exp(n + 15, 6'b0_11_000, "soft_n15");
        push_exp(n + 16, 6'b0_11_001, "soft_n16");
        push_exp(n + 24, 6'b0_11_111, "soft_n24");
        push_exp(n + 25, 6'b1_11_111, "soft_ready");
        wait_negedges(1);
        soft_rst = 1'b0;
        wait_negedges(29);
    endtask

    // Button bouncing every 3 cycles must never restart the sequence.
    task automatic button_bounce();
        int b;
        b = edge_cnt;
        for (int i = 1; i <= 12; i++) push_exp(b + 5 * i, 6'b1_11_111, "bounce_hold");
        for (int c = 0; c < 40; c++) begin
            btn_rst_n = ((c / 3) % 2 == 0) ? 1'b0 : 1'b1;
            wait_negedges(1);
        end
        btn_rst_n = 1'b1;
        wait_negedges(25);
    endtask

    // Button held low for 20 cycles: restart 10 edges after the first low
    // sample, stretch counting only after the debounced release.
    task automatic button_hold();
        int e1;
        e1 = edge_cnt + 1;
        btn_rst_n = 1'b0;
        push_exp(e1 + 9,  6'b1_11_111, "btn_pre");
        push_exp(e1 + 10, 6'b0_10_000, "btn_assert");
        push_exp(e1 + 25, 6'b0_10_000, "btn_held");
        push_exp(e1 + 44, 6'b0_10_000, "btn_stretch_end");
        push_exp(e1 + 45, 6'b0_10_001, "btn_rel0");
        push_exp(e1 + 53, 6'b0_10_111, "btn_rel2");
        push_exp(e1 + 54, 6'b1_10_111, "btn_ready");
        wait_negedges(20);
        btn_rst_n = 1'b1;
        wait_negedges(40);
    endtask

    // soft_rst coinciding with the debounced button fall: button wins.
    task automatic simultaneous();
        int e1;
        e1 = edge_cnt + 1;
        btn_rst_n = 1'b0;
        push_exp(e1 + 9,  6'b1_11_111, "simul_pre");
        push_exp(e1 + 10, 6'b0_10_000, "simul_assert");
        push_exp(e1 + 11, 6'b0_10_000, "simul_after");
        push_exp(e1 + 36, 6'b0_10_000, "simul_stretch_end");
        push_exp(e1 + 37, 6'b0_10_001, "simul_rel0");
        push_exp(e1 + 46, 6'b1_10_111, "simul_ready");
        wait_negedges(10);
        soft_rst = 1'b1;
        wait_negedges(1);
        soft_rst = 1'b0;
        wait_negedges(1);
        btn_rst_n = 1'b1;
        wait_negedges(40);
    endtask

    // Second soft_rst while the stretch count is 10: release slips 11 edges.
    task automatic soft_in_stretch();
        int n;
        n = edge_cnt + 1;
        soft_rst = 1'b1;
        push_exp(n,      6'b0_11_000, "stretch_first");
        push_exp(n + 16, 6'b0_11_000, "stretch_slipped");
        push_exp(n + 26, 6'b0_11_000, "stretch_n26");
        push_exp(n + 27, 6'b0_11_001, "stretch_rel0");
        push_exp(n + 35, 6'b0_11_111, "stretch_rel2");
        push_exp(n + 36, 6'b1_11_111, "stretch_ready");
        wait_negedges(1);
        soft_rst = 1'b0;
        wait_negedges(10);
        soft_rst = 1'b1;
        wait_negedges(1);
        soft_rst = 1'b0;
        wait_negedges(30);
    endtask

    // Async reset_n assertion from RUN and from mid-RELEASE.
    task automatic async_reset();
        int b;
        #2 reset_n = 1'b0;
        #1 check_eq("async_in_run", observed(), 6'b0_01_000);
        wait_negedges(3);
        b = edge_cnt;
        reset_n = 1'b1;
        push_exp(b + 22, 6'b0_01_011, "midrel_e22");
        push_exp(b + 23, 6'b0_01_011, "midrel_e23");
        wait_negedges(23);
        #2 reset_n = 1'b0;
        #1 check_eq("async_mid_release", observed(), 6'b0_01_000);
        wait_negedges(2);
        check_eq("held_in_reset", observed(), 6'b0_01_000);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset_n   = 1'b1;
        btn_rst_n = 1'b1;
        soft_rst  = 1'b0;
        #1 reset_n = 1'b0;
        wait_negedges(3);
        check_eq("reset_state", observed(), 6'b0_01_000);

        por_sequence();
        soft_pulse_run();
        button_bounce();
        button_hold();
        soft_pulse_run();
        simultaneous();
        soft_in_stretch();
        async_reset();
        por_sequence();

        while (exp_q.size() > 0) begin
            n_errors++;
            $display("FAIL %s: expectation for edge %0d never compared", exp_tag_q.pop_front(),
                     exp_edge_q.pop_front());
            void'(exp_q.pop_front());
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
